// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
//   Request arbiter and bus-hold sequencer for an NUM_CH-channel DMA controller.
//   Negotiates the bus with the CPU (HRQ/HLDA), picks the winning eligible
//   channel by rank in PRIORITY_ORDER, and drives a one-hot DACK while the
//   channel is serviced.
//
//   Optional feature macro: ROTATING_PRIORITY_EN
//     defined   - rotation logic present; PRIORITY_TYPE=1 rotates the order
//                 after every service, PRIORITY_TYPE=0 keeps identity order.
//     undefined - PRIORITY_TYPE ignored, PRIORITY_ORDER tied to identity.
module dma_channel_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_CH-1:0]      DREQ,
  input  logic [NUM_CH-1:0]      MASK,
  input  logic [NUM_CH-1:0]      BLOCK_MODE,
  input  logic                   PRIORITY_TYPE,
  input  logic                   HLDA,
  input  logic                   XFER_DONE,
  input  logic                   TC,
  input  logic                   EOP_N,
  output logic                   HRQ,
  output logic [NUM_CH-1:0]      DACK,
  output logic [CH_W-1:0]        ACTIVE_CH,
  output logic                   GRANT_VALID,
  output logic [NUM_CH*CH_W-1:0] PRIORITY_ORDER
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_SERVICE  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t                   state_reg;
  state_t                   state_next;

  logic [NUM_CH-1:0]        req;
  logic [CH_W-1:0]          winner;
  logic                     winner_found;
  logic                     service_exit;

  logic [CH_W-1:0]          active_reg;
  logic [CH_W-1:0]          active_next;
  logic                     hrq_reg;
  logic                     hrq_next;
  logic [NUM_CH-1:0]        dack_reg;
  logic [NUM_CH-1:0]        dack_next;
  logic                     grant_reg;
  logic                     grant_next;

  logic [NUM_CH*CH_W-1:0]   order_reg;
  logic [NUM_CH*CH_W-1:0]   order_identity;

  // Masked channels never compete for the bus.
  assign req = DREQ & ~MASK;

  // Identity order: rank r holds channel r.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_identity
    assign order_identity[gi*CH_W +: CH_W] = CH_W'(gi);
  end

`ifdef ROTATING_PRIORITY_EN
  logic [NUM_CH*CH_W-1:0] order_rotated;

  // Rotated order: channel after the serviced one takes rank 0, serviced
  // channel lands at the lowest rank.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rotate
    assign order_rotated[gi*CH_W +: CH_W] =
      CH_W'((32'(active_reg) + 32'(gi) + 32'd1) % 32'(NUM_CH));
  end

  // Priority order register: updated once per service, on the release cycle,
  // so reset mid-service abandons the rotation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      order_reg <= order_identity;
    end else if (state_reg == ST_RELEASE) begin
      order_reg <= PRIORITY_TYPE ? order_rotated : order_identity;
    end
  end
`else
  logic unused_priority_type;

  // Fixed priority only: the order never changes.
  assign order_reg            = order_identity;
  assign unused_priority_type = PRIORITY_TYPE;
`endif

  // Arbitration: scan ranks from highest to lowest, first eligible wins.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int r = 0; r < NUM_CH; r++) begin
      if (!winner_found && req[order_reg[r*CH_W +: CH_W]]) begin
        winner       = order_reg[r*CH_W +: CH_W];
        winner_found = 1'b1;
      end
    end
  end

  // Any of these ends the current service; they all share one release path.
  always_comb begin
    service_exit = (XFER_DONE && TC)
                || !EOP_N
                || (XFER_DONE && !BLOCK_MODE[active_reg])
                || !HLDA
                || MASK[active_reg];
  end

  // Next-state logic for the hold/service sequencer.
  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    case (state_reg)
      ST_IDLE: begin
        // A lingering HLDA from the previous hold blocks a new request.
        if ((|req) && !HLDA) begin
          state_next = ST_HOLD_REQ;
        end
      end
      ST_HOLD_REQ: begin
        if (HLDA && winner_found) begin
          state_next  = ST_SERVICE;
          active_next = winner;
        end else if (!winner_found) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (service_exit) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    hrq_next   = (state_next == ST_HOLD_REQ) || (state_next == ST_SERVICE);
    grant_next = (state_next == ST_SERVICE);
  end

  // One-hot acknowledge for the channel about to be (or being) serviced.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dack
    assign dack_next[gi] = grant_next && (active_next == CH_W'(gi));
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= ST_IDLE;
      active_reg <= '0;
      hrq_reg    <= 1'b0;
      dack_reg   <= '0;
      grant_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      hrq_reg    <= hrq_next;
      dack_reg   <= dack_next;
      grant_reg  <= grant_next;
    end
  end

  assign HRQ            = hrq_reg;
  assign DACK           = dack_reg;
  assign ACTIVE_CH      = active_reg;
  assign GRANT_VALID    = grant_reg;
  assign PRIORITY_ORDER = order_reg;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter
//   Directed bench for dma_channel_arbiter (NUM_CH = 4). Expected grants are
//   queued when a request is posed and popped when GRANT_VALID appears.
//   Follows ROTATING_PRIORITY_EN to pick the expected grant order.
module tb_dma_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      dreq;
  logic [NUM_CH-1:0]      mask;
  logic [NUM_CH-1:0]      block_mode;
  logic                   priority_type;
  logic                   hlda;
  logic                   xfer_done;
  logic                   tc;
  logic                   eop_n;
  logic                   hrq;
  logic [NUM_CH-1:0]      dack;
  logic [CH_W-1:0]        active_ch;
  logic                   grant_valid;
  logic [NUM_CH*CH_W-1:0] priority_order;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

`ifdef ROTATING_PRIORITY_EN
  int rot_seq[5]    = '{0, 1, 2, 3, 0};
  int rot_after_rst = 1;
  logic [7:0] order_after_first = 8'h39;
  logic [7:0] order_after_five  = 8'h39;
`else
  int rot_seq[5]    = '{0, 0, 0, 0, 0};
  int rot_after_rst = 0;
  logic [7:0] order_after_first = 8'hE4;
  logic [7:0] order_after_five  = 8'hE4;
`endif

  dma_channel_arbiter #(.NUM_CH(NUM_CH)) dut (
    .CLK            (clk),
    .RESET          (reset),
    .DREQ           (dreq),
    .MASK           (mask),
    .BLOCK_MODE     (block_mode),
    .PRIORITY_TYPE  (priority_type),
    .HLDA           (hlda),
    .XFER_DONE      (xfer_done),
    .TC             (tc),
    .EOP_N          (eop_n),
    .HRQ            (hrq),
    .DACK           (dack),
    .ACTIVE_CH      (active_ch),
    .GRANT_VALID    (grant_valid),
    .PRIORITY_ORDER (priority_order)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while (hrq !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    check(tag, hrq, 1);
  endtask

  task automatic wait_grant(input string tag, output int lat);
    int         n;
    int         e;
    logic [3:0] oh;
    n = 0;
    while (grant_valid !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    lat = n;
    e   = exp_q.pop_front();
    oh  = 4'b0001;
    oh  = oh << e;
    $display("grant %s: dack=%b active_ch=%0d expected_ch=%0d latency=%0d",
             tag, dack, active_ch, e, n);
    check({tag, "_gv"},   grant_valid, 1);
    check({tag, "_dack"}, dack, oh);
    check({tag, "_ch"},   active_ch, e);
  endtask

  initial begin
    int lat;
    reset = 1'b1; dreq = '0; mask = '0; block_mode = '0; priority_type = 1'b0;
    hlda = 1'b0; xfer_done = 1'b0; tc = 1'b0; eop_n = 1'b1;
    cyc(3);
    check("rst_hrq",   hrq, 0);
    check("rst_dack",  dack, 0);
    check("rst_ch",    active_ch, 0);
    check("rst_gv",    grant_valid, 0);
    check("rst_order", priority_order, 8'hE4);
    reset = 1'b0;
    cyc(1);
    check("idle_hrq", hrq, 0);

    // Fixed priority: channel 1 beats channel 3.
    dreq = 4'b1010;
    cyc(1);
    check("t1_hrq_rise", hrq, 1);
    cyc(1);
    hlda = 1'b1;
    exp_q.push_back(1);
    wait_grant("t1", lat);
    check("t1_latency", lat, 1);
    check("t1_hrq_svc", hrq, 1);
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    check("t1_rel_hrq",  hrq, 0);
    check("t1_rel_dack", dack, 0);
    check("t1_rel_gv",   grant_valid, 0);
    hlda = 1'b0; dreq = '0;
    cyc(2);

    // Rotating priority, all channels requesting, single transfers.
    priority_type = 1'b1;
    dreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(rot_seq[k]);
      wait_hrq("rot_hrq");
      hlda = 1'b1;
      wait_grant("rot", lat);
      xfer_done = 1'b1;
      cyc(1);
      xfer_done = 1'b0;
      hlda = 1'b0;
      cyc(1);
      if (k == 0) check("rot_order_first", priority_order, order_after_first);
    end

    // Reset during service abandons the rotated order.
    exp_q.push_back(rot_after_rst);
    wait_hrq("rst_svc_hrq");
    hlda = 1'b1;
    wait_grant("rst_svc", lat);
    check("rst_svc_order_before", priority_order, order_after_five);
    reset = 1'b1;
    cyc(1);
    check("rst_svc_hrq",   hrq, 0);
    check("rst_svc_dack",  dack, 0);
    check("rst_svc_ch",    active_ch, 0);
    check("rst_svc_gv",    grant_valid, 0);
    check("rst_svc_order", priority_order, 8'hE4);
    reset = 1'b0; hlda = 1'b0; dreq = '0; priority_type = 1'b0;
    cyc(2);

    // Block mode on channel 2: three non-terminal transfers then TC.
    dreq = 4'b0100; block_mode = 4'b0100;
    exp_q.push_back(2);
    wait_hrq("blk_hrq");
    hlda = 1'b1;
    wait_grant("blk", lat);
    for (int i = 0; i < 3; i++) begin
      xfer_done = 1'b1;
      cyc(1);
      xfer_done = 1'b0;
      check("blk_hold_dack", dack, 4'b0100);
      cyc(1);
    end
    xfer_done = 1'b1; tc = 1'b1;
    cyc(1);
    xfer_done = 1'b0; tc = 1'b0;
    check("blk_tc_hrq",  hrq, 0);
    check("blk_tc_dack", dack, 0);
    cyc(2);
    check("blk_no_rereq_hlda", hrq, 0);
    hlda = 1'b0;
    cyc(1);
    check("blk_rereq_hrq", hrq, 1);
    // Withdraw the request before HLDA arrives.
    dreq = '0;
    cyc(1);
    check("withdraw_hrq", hrq, 0);
    cyc(2);
    check("withdraw_dack", dack, 0);

    // EOP_N mid-block ends service immediately.
    dreq = 4'b0100;
    exp_q.push_back(2);
    wait_hrq("eop_hrq");
    hlda = 1'b1;
    wait_grant("eop", lat);
    xfer_done = 1'b1;
    cyc(1);
    xfer_done = 1'b0;
    check("eop_pre_dack", dack, 4'b0100);
    eop_n = 1'b0;
    cyc(1);
    eop_n = 1'b1;
    check("eop_dack", dack, 0);
    check("eop_hrq",  hrq, 0);
    cyc(1);
    check("eop_idle_hrq", hrq, 0);
    dreq = '0; hlda = 1'b0; block_mode = '0;
    cyc(1);

    // Bus lost: HLDA drops during service.
    dreq = 4'b0001;
    exp_q.push_back(0);
    wait_hrq("lost_hrq");
    hlda = 1'b1;
    wait_grant("lost", lat);
    hlda = 1'b0;
    cyc(1);
    check("lost_dack", dack, 0);
    check("lost_gv",   grant_valid, 0);
    dreq = '0;
    cyc(2);

    // Masked-only request never raises HRQ.
    dreq = 4'b0001; mask = 4'b0001;
    cyc(4);
    check("masked_hrq",  hrq, 0);
    check("masked_dack", dack, 0);

    // Masking the active channel ends service.
    mask = '0; dreq = 4'b0011;
    exp_q.push_back(0);
    wait_hrq("mask_svc_hrq");
    hlda = 1'b1;
    wait_grant("mask_svc", lat);
    mask = 4'b0001;
    cyc(1);
    check("mask_svc_dack", dack, 0);
    check("mask_svc_hrq",  hrq, 0);
    mask = '0; dreq = '0; hlda = 1'b0;
    cyc(2);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
